// File: rtl/latch_frame_receiver.sv
// Serial start/data/parity/stop frame receiver fed by the latch Q output.
// Samples one bit per BIT_EN strobe and emits a word with valid and error pulses.
module latch_frame_receiver #(
  parameter int WIDTH      = 8,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             D_IN,
  input  logic             BIT_EN,
  output logic [WIDTH-1:0] DATA,
  output logic             DATA_VALID,
  output logic             PARITY_ERR,
  output logic             FRAME_ERR,
  output logic             BUSY
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             perr_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      cnt        <= '0;
      shreg      <= '0;
      perr_q     <= 1'b0;
      DATA       <= '0;
      DATA_VALID <= 1'b0;
      PARITY_ERR <= 1'b0;
      FRAME_ERR  <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      FRAME_ERR  <= 1'b0;
      if (BIT_EN) begin
        unique case (state)
          S_IDLE: begin
            if (!D_IN) begin
              state  <= S_DATA;
              cnt    <= '0;
              shreg  <= '0;
              perr_q <= 1'b0;
              BUSY   <= 1'b1;
            end
          end
          S_DATA: begin
            for (int i = 0; i < WIDTH; i++) begin
              if (cnt == CW'(i)) shreg[i] <= D_IN;
            end
            cnt <= cnt + CW'(1);
            if (cnt == LAST) begin
              state <= PARITY_EN ? S_PARITY : S_STOP;
            end
          end
          S_PARITY: begin
            perr_q <= D_IN != ((^shreg) ^ PARITY_ODD);
            state  <= S_STOP;
          end
          S_STOP: begin
            if (D_IN) begin
              DATA       <= shreg;
              DATA_VALID <= 1'b1;
              PARITY_ERR <= PARITY_EN ? perr_q : 1'b0;
              state      <= S_IDLE;
              BUSY       <= 1'b0;
            end else begin
              // framing errors never report parity
              FRAME_ERR  <= 1'b1;
              PARITY_ERR <= 1'b0;
              state      <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (D_IN) begin
              state <= S_IDLE;
              BUSY  <= 1'b0;
            end
          end
          default: begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_latch_frame_receiver.sv
// Scoreboard bench for latch_frame_receiver: even-parity and no-parity instances.
// Expected words are queued by the stimulus and popped by per-instance monitors.
module tb_latch_frame_receiver;

  logic       clk;
  logic       rst_n;
  logic       d0, en0, d1, en1;
  logic [7:0] data0, data1;
  logic       dv0, pe0, fe0, busy0;
  logic       dv1, pe1, fe1, busy1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         fe;
    logic [7:0] data;
    bit         perr;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  latch_frame_receiver #(.WIDTH(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u0 (
    .CLK(clk), .RST_N(rst_n), .D_IN(d0), .BIT_EN(en0),
    .DATA(data0), .DATA_VALID(dv0), .PARITY_ERR(pe0),
    .FRAME_ERR(fe0), .BUSY(busy0)
  );

  latch_frame_receiver #(.WIDTH(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u1 (
    .CLK(clk), .RST_N(rst_n), .D_IN(d1), .BIT_EN(en1),
    .DATA(data1), .DATA_VALID(dv1), .PARITY_ERR(pe1),
    .FRAME_ERR(fe1), .BUSY(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon_cmp(input string tag, input exp_t e, input logic [7:0] d,
                         input logic dv, input logic pe, input logic fe);
    checks++;
    if (dv !== !e.fe || fe !== e.fe || d !== e.data || pe !== e.perr) begin
      errors++;
      $display("FAIL %s: got dv=%b fe=%b data=%h pe=%b expected dv=%b fe=%b data=%h pe=%b",
               tag, dv, fe, d, pe, !e.fe, e.fe, e.data, e.perr);
    end
  endtask

  always @(negedge clk) begin
    if (dv0 || fe0) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon0: unexpected dv=%b fe=%b data=%h expected no event",
                 dv0, fe0, data0);
      end else begin
        mon_cmp("mon0", q0.pop_front(), data0, dv0, pe0, fe0);
      end
    end
  end

  always @(negedge clk) begin
    if (dv1 || fe1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon1: unexpected dv=%b fe=%b data=%h expected no event",
                 dv1, fe1, data1);
      end else begin
        mon_cmp("mon1", q1.pop_front(), data1, dv1, pe1, fe1);
      end
    end
  end

  // Called just after a falling edge; sampled at the next rising edge.
  task automatic strobe(input int sel, input bit b, input int gap);
    if (sel == 0) begin
      d0 = b; en0 = 1'b1;
    end else begin
      d1 = b; en1 = 1'b1;
    end
    @(negedge clk);
    en0 = 1'b0;
    en1 = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic frame(input int sel, input logic [7:0] v, input bit par,
                       input bit stop, input int gap);
    strobe(sel, 1'b0, gap);
    for (int i = 0; i < 8; i++) strobe(sel, v[i], gap);
    if (sel == 0) strobe(sel, par, gap);
    strobe(sel, stop, gap);
  endtask

  initial begin
    rst_n = 1'b0;
    d0 = 1'b1; en0 = 1'b0;
    d1 = 1'b1; en1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_data", 32'(data0), 32'h0);
    chk("rst_dv", 32'(dv0), 32'h0);
    chk("rst_pe", 32'(pe0), 32'h0);
    chk("rst_fe", 32'(fe0), 32'h0);
    chk("rst_busy", 32'(busy0), 32'h0);
    chk("rst_busy1", 32'(busy1), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 0xA5, correct even parity, back-to-back strobes
    q0.push_back('{1'b0, 8'hA5, 1'b0});
    frame(0, 8'hA5, 1'b0, 1'b1, 0);
    chk("a5_latency", 32'(dv0), 32'h1);
    chk("a5_busy_end", 32'(busy0), 32'h0);

    // 0x55 with bad stop, line held low afterwards
    q0.push_back('{1'b1, 8'hA5, 1'b0});
    frame(0, 8'h55, 1'b0, 1'b0, 0);
    chk("fe_pulse", 32'(fe0), 32'h1);
    chk("fe_busy", 32'(busy0), 32'h1);
    for (int i = 0; i < 5; i++) begin
      strobe(0, 1'b0, 0);
      chk("wait_busy", 32'(busy0), 32'h1);
      chk("wait_fe_low", 32'(fe0), 32'h0);
    end
    chk("fe_data_hold", 32'(data0), 32'hA5);
    strobe(0, 1'b1, 0);
    chk("wait_exit_busy", 32'(busy0), 32'h0);
    for (int i = 0; i < 3; i++) begin
      strobe(0, 1'b1, 0);
      chk("post_wait_idle", 32'(busy0), 32'h0);
    end

    // 0x07 with wrong parity, then 0x3C clears the flag
    q0.push_back('{1'b0, 8'h07, 1'b1});
    frame(0, 8'h07, 1'b0, 1'b1, 0);
    chk("p07_perr", 32'(pe0), 32'h1);
    q0.push_back('{1'b0, 8'h3C, 1'b0});
    frame(0, 8'h3C, 1'b0, 1'b1, 0);
    chk("p3c_perr", 32'(pe0), 32'h0);

    // 0xA5 strobed every 4th cycle
    q0.push_back('{1'b0, 8'hA5, 1'b0});
    frame(0, 8'hA5, 1'b0, 1'b1, 3);
    chk("slow_data", 32'(data0), 32'hA5);
    chk("slow_dv_low", 32'(dv0), 32'h0);

    // reset after start + 3 data bits
    strobe(0, 1'b0, 0);
    strobe(0, 1'b1, 0);
    strobe(0, 1'b0, 0);
    strobe(0, 1'b1, 0);
    chk("mid_busy", 32'(busy0), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_data", 32'(data0), 32'h0);
    chk("arst_busy", 32'(busy0), 32'h0);
    chk("arst_pe", 32'(pe0), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    q0.push_back('{1'b0, 8'h3C, 1'b0});
    frame(0, 8'h3C, 1'b0, 1'b1, 0);
    chk("post_rst_data", 32'(data0), 32'h3C);

    // idle line high
    for (int i = 0; i < 20; i++) begin
      strobe(0, 1'b1, 0);
      chk("idle_busy", 32'(busy0), 32'h0);
    end

    // no-parity instance, 0x81
    q1.push_back('{1'b0, 8'h81, 1'b0});
    frame(1, 8'h81, 1'b0, 1'b1, 0);
    chk("np_dv", 32'(dv1), 32'h1);
    chk("np_data", 32'(data1), 32'h81);
    chk("np_perr", 32'(pe1), 32'h0);

    repeat (3) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'h0);
    chk("q1_drained", 32'(q1.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
